periph_timer_gpio: RTL and testbench

Parametrised memory-mapped peripheral combining a GPIO port of configurable width, rising-edge capture flags with an interrupt line, and a programmable tick generator. The tick generator replaces the fixed 25,000,000-count 1 Hz divider with a runtime-programmable divider. The block sits on the RV32I data bus behind the memory controller as one address window. Reads are zero-latency for the single-cycle core.

---
 rtl/fe_pkg.sv | 21 ++
 rtl/periph_timer_gpio_tick_divider.sv | 31 +++
 rtl/periph_timer_gpio.sv | 121 ++++++++++++
 tb/tb_periph_timer_gpio.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared front-end definitions: RV32I operand types plus the register map and
// control-bit layout of the timer/GPIO peripheral, used by RTL and firmware alike.
package fe_pkg;

  typedef logic [31:0] rv_word_t;
  typedef logic [4:0]  rv_reg_t;
  typedef logic [11:0] rv_imm12_t;

  localparam logic [7:0] OFF_GPIO_IN    = 8'h00;
  localparam logic [7:0] OFF_GPIO_OUT   = 8'h04;
  localparam logic [7:0] OFF_GPIO_SET   = 8'h08;
  localparam logic [7:0] OFF_GPIO_CLR   = 8'h0C;
  localparam logic [7:0] OFF_EDGE_FLAGS = 8'h10;
  localparam logic [7:0] OFF_EDGE_MASK  = 8'h14;
  localparam logic [7:0] OFF_TICK_DIV   = 8'h18;
  localparam logic [7:0] OFF_TICK_CTRL  = 8'h1C;

  localparam int TICK_CTRL_EN_BIT  = 0;
  localparam int TICK_CTRL_CLR_BIT = 1;

endpackage

// File: rtl/periph_timer_gpio_tick_divider.sv
// Programmable terminal-count divider: counts 0..div while enabled and pulses
// hit for one cycle at the terminal count.
module tick_divider
  import fe_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [DATA_WIDTH-1:0] div,
  output logic                  hit
);

  logic [DATA_WIDTH-1:0] cnt;

  // A terminal count coinciding with a restart still counts as a hit.
  assign hit = enable && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || hit) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/periph_timer_gpio.sv
// Memory-mapped GPIO port with rising-edge capture flags, an interrupt line and
// a runtime-programmable tick generator, decoded within one bus window.
module periph_timer_gpio
  import fe_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          GPIO_WIDTH   = 8,
  parameter int          OFFSET_WIDTH = 5,
  parameter logic [31:0] DEFAULT_DIV  = 32'd24_999_999
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OFFSET_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0]   bus_wrdata,
  input  logic                    bus_wren,
  output logic [DATA_WIDTH-1:0]   bus_rddata,
  input  logic [GPIO_WIDTH-1:0]   gpio_port_in,
  output logic [GPIO_WIDTH-1:0]   gpio_port_out,
  output logic                    tick_out,
  output logic                    irq
);

  logic [OFFSET_WIDTH-1:0] off;
  logic                    unused_addr_bits;
  logic [GPIO_WIDTH-1:0]   wdata_g;
  logic wr_out, wr_set, wr_clr, wr_flags, wr_mask, wr_div, wr_ctrl;

  logic [GPIO_WIDTH-1:0] sync1, sync2, hist;
  logic [GPIO_WIDTH-1:0] gpio_out, flags, mask, rise;
  logic [DATA_WIDTH-1:0] tick_div;
  logic                  tick_en, tick_q, tick_hit, irq_q;
  logic [31:0]           tick_count;

  // Byte lanes are not decoded; every register is word-aligned.
  assign off              = {bus_addr[OFFSET_WIDTH-1:2], 2'b00};
  assign unused_addr_bits = ^bus_addr[1:0];
  assign wdata_g          = bus_wrdata[GPIO_WIDTH-1:0];

  assign wr_out   = bus_wren && (off == OFFSET_WIDTH'(OFF_GPIO_OUT));
  assign wr_set   = bus_wren && (off == OFFSET_WIDTH'(OFF_GPIO_SET));
  assign wr_clr   = bus_wren && (off == OFFSET_WIDTH'(OFF_GPIO_CLR));
  assign wr_flags = bus_wren && (off == OFFSET_WIDTH'(OFF_EDGE_FLAGS));
  assign wr_mask  = bus_wren && (off == OFFSET_WIDTH'(OFF_EDGE_MASK));
  assign wr_div   = bus_wren && (off == OFFSET_WIDTH'(OFF_TICK_DIV));
  assign wr_ctrl  = bus_wren && (off == OFFSET_WIDTH'(OFF_TICK_CTRL));

  assign rise = sync2 & ~hist;

  tick_divider #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tick_divider (
    .clk    (clk),
    .rst    (rst),
    .enable (tick_en),
    .restart(wr_div || wr_ctrl),
    .div    (tick_div),
    .hit    (tick_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      hist       <= '0;
      gpio_out   <= '0;
      flags      <= '0;
      mask       <= '0;
      irq_q      <= 1'b0;
      tick_div   <= DATA_WIDTH'(DEFAULT_DIV);
      tick_en    <= 1'b1;
      tick_q     <= 1'b0;
      tick_count <= '0;
    end else begin
      sync1 <= gpio_port_in;
      sync2 <= sync1;
      hist  <= sync2;

      if (wr_out) begin
        gpio_out <= wdata_g;
      end else if (wr_set) begin
        gpio_out <= gpio_out | wdata_g;
      end else if (wr_clr) begin
        gpio_out <= gpio_out & ~wdata_g;
      end

      // A new edge beats a simultaneous write-one-to-clear.
      flags <= (flags & ~(wr_flags ? wdata_g : '0)) | rise;
      if (wr_mask) mask <= wdata_g;
      irq_q <= |(flags & mask);

      if (wr_div)  tick_div <= bus_wrdata;
      if (wr_ctrl) tick_en  <= bus_wrdata[TICK_CTRL_EN_BIT];
      if (tick_hit) tick_q  <= ~tick_q;

      if (wr_ctrl && bus_wrdata[TICK_CTRL_CLR_BIT]) begin
        tick_count <= '0;
      end else if (tick_hit) begin
        tick_count <= tick_count + 32'd1;
      end
    end
  end

  always_comb begin
    bus_rddata = '0;
    case (off)
      OFFSET_WIDTH'(OFF_GPIO_IN):    bus_rddata = DATA_WIDTH'(sync2);
      OFFSET_WIDTH'(OFF_GPIO_OUT):   bus_rddata = DATA_WIDTH'(gpio_out);
      OFFSET_WIDTH'(OFF_EDGE_FLAGS): bus_rddata = DATA_WIDTH'(flags);
      OFFSET_WIDTH'(OFF_EDGE_MASK):  bus_rddata = DATA_WIDTH'(mask);
      OFFSET_WIDTH'(OFF_TICK_DIV):   bus_rddata = tick_div;
      // Control bits are not readable; the slot carries the low 30 bits of TICK_COUNT.
      OFFSET_WIDTH'(OFF_TICK_CTRL):  bus_rddata = DATA_WIDTH'({tick_count[29:0], 2'b00});
      default:                       bus_rddata = '0;
    endcase
  end

  assign gpio_port_out = gpio_out;
  assign tick_out      = tick_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_periph_timer_gpio.sv
// Randomised and directed bench for periph_timer_gpio against a register-level
// behavioural model of the peripheral.
module tb_periph_timer_gpio;

  localparam int          DW      = 32;
  localparam int          GW      = 8;
  localparam int          OW      = 5;
  localparam logic [31:0] DEF_DIV = 32'd24_999_999;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] bus_addr;
  logic [DW-1:0] bus_wrdata;
  logic          bus_wren;
  logic [DW-1:0] bus_rddata;
  logic [GW-1:0] gpio_port_in;
  logic [GW-1:0] gpio_port_out;
  logic          tick_out;
  logic          irq;

  always #5 clk = ~clk;

  periph_timer_gpio #(
    .DATA_WIDTH  (DW),
    .GPIO_WIDTH  (GW),
    .OFFSET_WIDTH(OW),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_addr     (bus_addr),
    .bus_wrdata   (bus_wrdata),
    .bus_wren     (bus_wren),
    .bus_rddata   (bus_rddata),
    .gpio_port_in (gpio_port_in),
    .gpio_port_out(gpio_port_out),
    .tick_out     (tick_out),
    .irq          (irq)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tick state is kept as "enabled cycles since last restart"; terminal counts
  // elapsed are that number divided by the period, folded in on every restart.
  logic [7:0]  m_out, m_flags, m_mask;
  logic        m_irq, m_en, m_tbase;
  logic [31:0] m_div, m_cbase;
  longint      m_run;
  logic [7:0]  pin_q[$];
  logic [7:0]  cur_pins;

  function automatic logic [31:0] hits();
    return 32'(m_run / (longint'(m_div) + 64'd1));
  endfunction

  function automatic logic exp_tick();
    logic [31:0] h;
    h = hits();
    return m_tbase ^ h[0];
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] c;
    c = m_cbase + hits();
    case (a[4:2])
      3'd0:    return 32'(pin_q[1]);
      3'd1:    return 32'(m_out);
      3'd4:    return 32'(m_flags);
      3'd5:    return 32'(m_mask);
      3'd6:    return m_div;
      3'd7:    return {c[29:0], 2'b00};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_out   = '0;
    m_flags = '0;
    m_mask  = '0;
    m_irq   = 1'b0;
    m_en    = 1'b1;
    m_tbase = 1'b0;
    m_div   = DEF_DIV;
    m_cbase = '0;
    m_run   = 0;
    pin_q   = '{8'h00, 8'h00, 8'h00};
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [4:0] a,
                            input logic [31:0] d, input logic [7:0] p);
    logic [7:0]  rise, dg, dummy;
    logic [2:0]  idx;
    logic [31:0] h;
    if (r) begin
      model_reset();
      return;
    end
    rise  = pin_q[1] & ~pin_q[2];
    m_irq = |(m_flags & m_mask);
    dg    = d[7:0];
    idx   = a[4:2];
    if (w && idx == 3'd1) m_out = dg;
    if (w && idx == 3'd2) m_out = m_out | dg;
    if (w && idx == 3'd3) m_out = m_out & ~dg;
    if (w && idx == 3'd4) m_flags = m_flags & ~dg;
    m_flags = m_flags | rise;
    if (w && idx == 3'd5) m_mask = dg;
    if (m_en) m_run++;
    if (w && (idx == 3'd6 || idx == 3'd7)) begin
      h       = hits();
      m_cbase = m_cbase + h;
      m_tbase = m_tbase ^ h[0];
      m_run   = 0;
      if (idx == 3'd7) begin
        m_en = d[0];
        if (d[1]) m_cbase = '0;
      end else begin
        m_div = d;
      end
    end
    pin_q.push_front(p);
    dummy = pin_q.pop_back();
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input bit chk, input logic [31:0] exp_rd, input string tag);
    rst          = r;
    bus_wren     = w;
    bus_addr     = a;
    bus_wrdata   = d;
    gpio_port_in = cur_pins;
    #1;
    if (!r && !w) begin
      exp_q.push_back(model_read(a));
      check($sformatf("rd@%h", a), bus_rddata, exp_q.pop_front());
      if (chk) check(tag, bus_rddata, exp_rd);
    end
    @(posedge clk);
    model_edge(r, w, a, d, cur_pins);
    #1;
    check("gpio_out", 32'(gpio_port_out), 32'(m_out));
    check("tick_out", 32'(tick_out), 32'(exp_tick()));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b0, 1'b0, a, 32'd0, 1'b0, 32'd0, "");
  endtask

  task automatic rd_exp(input string tag, input logic [4:0] a, input logic [31:0] e);
    step(1'b0, 1'b0, a, 32'd0, 1'b1, e, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(5'($urandom_range(0, 31)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  ra;
    logic [31:0] rdv;
    int          op;
    rst          = 1'b1;
    bus_wren     = 1'b0;
    bus_addr     = '0;
    bus_wrdata   = '0;
    cur_pins     = '0;
    gpio_port_in = '0;
    model_reset();
    step(1'b1, 1'b0, 5'h00, 32'd0, 1'b0, 32'd0, "");
    step(1'b1, 1'b0, 5'h00, 32'd0, 1'b0, 32'd0, "");

    // Reset values of every offset
    for (int i = 0; i < 8; i++) begin
      ra = 5'(i * 4);
      rd_exp($sformatf("reset_rd@%h", ra), ra, (i == 6) ? DEF_DIV : 32'd0);
    end
    check("reset_gpio_out", 32'(gpio_port_out), 32'd0);
    check("reset_tick_out", 32'(tick_out), 32'd0);

    // GPIO_OUT / SET / CLR
    wr(5'h04, 32'hA5);
    check("out_a5", 32'(gpio_port_out), 32'hA5);
    wr(5'h08, 32'h0F);
    check("out_af", 32'(gpio_port_out), 32'hAF);
    wr(5'h0C, 32'h81);
    check("out_2e", 32'(gpio_port_out), 32'h2E);
    rd_exp("set_reads0", 5'h08, 32'd0);
    rd_exp("clr_reads0", 5'h0C, 32'd0);

    // Edge capture and irq latency
    wr(5'h14, 32'h08);
    cur_pins = 8'h08;
    idle(3);
    check("irq_lag", 32'(irq), 32'd0);
    rd_exp("flag_set", 5'h10, 32'h08);
    check("irq_set", 32'(irq), 32'd1);

    // New rise arriving in the same cycle as its W1C
    cur_pins = 8'h00;
    idle(4);
    cur_pins = 8'h08;
    idle(2);
    wr(5'h10, 32'h08);
    rd_exp("w1c_set_wins", 5'h10, 32'h08);
    wr(5'h10, 32'h08);
    rd_exp("w1c_clear", 5'h10, 32'h00);
    idle(2);

    // Tick divider with period 4
    wr(5'h18, 32'd3);
    idle(40);
    rd_exp("tick_count10", 5'h1C, 32'h28);
    wr(5'h1C, 32'h3);
    rd_exp("tick_clear", 5'h1C, 32'h0);
    idle(12);

    // TICK_DIV = 0 then disable
    wr(5'h18, 32'd0);
    idle(6);
    wr(5'h1C, 32'd0);
    idle(6);
    rd(5'h1C);

    // Reset mid-count with outputs and flags active; the write is discarded
    wr(5'h1C, 32'd1);
    wr(5'h18, 32'd5);
    wr(5'h04, 32'hFF);
    cur_pins = 8'hF8;
    idle(5);
    step(1'b1, 1'b1, 5'h04, 32'h55, 1'b0, 32'd0, "");
    check("mid_rst_gpio_out", 32'(gpio_port_out), 32'd0);
    check("mid_rst_tick_out", 32'(tick_out), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    rd_exp("mid_rst_flags", 5'h10, 32'd0);
    rd_exp("mid_rst_div", 5'h18, DEF_DIV);
    rd_exp("mid_rst_count", 5'h1C, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) cur_pins = 8'($urandom);
      op = $urandom_range(0, 99);
      ra = 5'($urandom_range(0, 31));
      if (op < 2) begin
        step(1'b1, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0, 32'd0, "");
      end else if (op < 40) begin
        rdv = $urandom;
        if (ra[4:2] == 3'd6 && $urandom_range(0, 7) != 0) rdv = 32'($urandom_range(0, 9));
        if (ra[4:2] == 3'd7) rdv[0] = ($urandom_range(0, 3) != 0);
        wr(ra, rdv);
      end else begin
        rd(ra);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
